// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with stall/flush, bubble insertion and retire counter
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             per-stage stall vector; only bits STAGE_IDX (mem) and STAGE_IDX+1 (wb) are used
//   flush             squash this stage (bubble), overrides stall
//   cnt_clr           synchronous clear of retire_cnt
//   mem_*             GPR / HI-LO / LLbit write-back request from the memory stage
//   wb_*              registered copy presented to the write-back ports
//   retire_cnt        saturating count of captured GPR-writing instructions
module mem_wb_stage #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int STALL_W   = 6,
   parameter int STAGE_IDX = 4,
   parameter int CNT_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               cnt_clr,
   input  logic [DATA_W-1:0]  mem_wdata,
   input  logic [ADDR_W-1:0]  mem_wd,
   input  logic               mem_wreg,
   input  logic               mem_whilo,
   input  logic [DATA_W-1:0]  mem_hi,
   input  logic [DATA_W-1:0]  mem_lo,
   input  logic               mem_llbit_we,
   input  logic               mem_llbit_value,
   output logic [DATA_W-1:0]  wb_wdata,
   output logic [ADDR_W-1:0]  wb_wd,
   output logic               wb_wreg,
   output logic               wb_whilo,
   output logic [DATA_W-1:0]  wb_hi,
   output logic [DATA_W-1:0]  wb_lo,
   output logic               wb_llbit_we,
   output logic               wb_llbit_value,
   output logic [CNT_W-1:0]   retire_cnt
);

   logic               s_mem;
   logic               s_wb;
   logic               bubble;
   logic               capture;
   logic               unused_stall;

   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [ADDR_W-1:0]  wd_q, wd_d;
   logic               wreg_q, wreg_d;
   logic               whilo_q, whilo_d;
   logic [DATA_W-1:0]  hi_q, hi_d;
   logic [DATA_W-1:0]  lo_q, lo_d;
   logic               llbit_we_q, llbit_we_d;
   logic               llbit_value_q, llbit_value_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign s_mem = stall[STAGE_IDX];
   assign s_wb  = stall[STAGE_IDX+1];

   // Other stages' stall bits are deliberately ignored.
   assign unused_stall = ^stall;

   // Flush wins over any stall; a stalled mem stage feeding a running wb
   // stage must hand it a NOP rather than repeat the previous instruction.
   assign bubble  = flush || (s_mem && !s_wb);
   assign capture = !flush && !s_mem;

   always_comb begin
      // Default: hold (s_mem=1, s_wb=1). mem_* is never looked at here,
      // so X on a stalled memory stage cannot leak into wb_*.
      wdata_d       = wdata_q;
      wd_d          = wd_q;
      wreg_d        = wreg_q;
      whilo_d       = whilo_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      llbit_we_d    = llbit_we_q;
      llbit_value_d = llbit_value_q;

      if (bubble) begin
         wdata_d       = '0;
         wd_d          = '0;
         wreg_d        = 1'b0;
         whilo_d       = 1'b0;
         hi_d          = '0;
         lo_d          = '0;
         llbit_we_d    = 1'b0;
         llbit_value_d = 1'b0;
      end else if (capture) begin
         wdata_d       = mem_wdata;
         wd_d          = mem_wd;
         wreg_d        = mem_wreg;
         whilo_d       = mem_whilo;
         hi_d          = mem_hi;
         lo_d          = mem_lo;
         llbit_we_d    = mem_llbit_we;
         llbit_value_d = mem_llbit_value;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (capture && mem_wreg && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdata_q       <= '0;
         wd_q          <= '0;
         wreg_q        <= 1'b0;
         whilo_q       <= 1'b0;
         hi_q          <= '0;
         lo_q          <= '0;
         llbit_we_q    <= 1'b0;
         llbit_value_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         wdata_q       <= wdata_d;
         wd_q          <= wd_d;
         wreg_q        <= wreg_d;
         whilo_q       <= whilo_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         llbit_we_q    <= llbit_we_d;
         llbit_value_q <= llbit_value_d;
         cnt_q         <= cnt_d;
      end
   end

   assign wb_wdata       = wdata_q;
   assign wb_wd          = wd_q;
   assign wb_wreg        = wreg_q;
   assign wb_whilo       = whilo_q;
   assign wb_hi          = hi_q;
   assign wb_lo          = lo_q;
   assign wb_llbit_we    = llbit_we_q;
   assign wb_llbit_value = llbit_value_q;
   assign retire_cnt     = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard testbench for mem_wb_stage
module tb_mem_wb_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SW = 6;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] stall;
   logic          flush;
   logic          cnt_clr;
   logic [DW-1:0] mem_wdata;
   logic [AW-1:0] mem_wd;
   logic          mem_wreg;
   logic          mem_whilo;
   logic [DW-1:0] mem_hi;
   logic [DW-1:0] mem_lo;
   logic          mem_llbit_we;
   logic          mem_llbit_value;
   logic [DW-1:0] wb_wdata;
   logic [AW-1:0] wb_wd;
   logic          wb_wreg;
   logic          wb_whilo;
   logic [DW-1:0] wb_hi;
   logic [DW-1:0] wb_lo;
   logic          wb_llbit_we;
   logic          wb_llbit_value;
   logic [CW-1:0] retire_cnt;

   always #5 clk = ~clk;

   mem_wb_stage #(
      .DATA_W(DW), .ADDR_W(AW), .STALL_W(SW), .STAGE_IDX(4), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
      .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
      .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
      .retire_cnt(retire_cnt)
   );

   typedef struct packed {
      logic [DW-1:0] wdata;
      logic [AW-1:0] wd;
      logic          wreg;
      logic          whilo;
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
      logic          llwe;
      logic          llval;
      logic [CW-1:0] cnt;
   } wbv_t;

   wbv_t exp_q[$];
   int   id_q[$];
   int   checks = 0;
   int   passed = 0;
   int   step   = 0;
   wbv_t act;
   wbv_t e;
   int   eid;

   assign act = {wb_wdata, wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo,
                 wb_llbit_we, wb_llbit_value, retire_cnt};

   // Monitor: every rising edge produces one wb_* state; compare it against
   // the oldest expectation issued by the driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            eid = id_q.pop_front();
            checks++;
            if (act === e) begin
               passed++;
            end else begin
               $display("FAIL step%0d wb: got wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h llwe=%b llval=%b cnt=%0d, expected wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h llwe=%b llval=%b cnt=%0d",
                        eid, act.wdata, act.wd, act.wreg, act.whilo, act.hi, act.lo, act.llwe, act.llval, act.cnt,
                        e.wdata, e.wd, e.wreg, e.whilo, e.hi, e.lo, e.llwe, e.llval, e.cnt);
            end
         end
      end
   end

   task automatic ctl(input logic r, input logic [SW-1:0] s, input logic f, input logic c);
      rst = r; stall = s; flush = f; cnt_clr = c;
   endtask

   task automatic inp(input logic [DW-1:0] wdata, input logic [AW-1:0] wd, input logic wreg,
                      input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                      input logic llwe, input logic llval);
      mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg; mem_whilo = whilo;
      mem_hi = hi; mem_lo = lo; mem_llbit_we = llwe; mem_llbit_value = llval;
   endtask

   task automatic inp_x();
      mem_wdata = 'x; mem_wd = 'x; mem_wreg = 1'bx; mem_whilo = 1'bx;
      mem_hi = 'x; mem_lo = 'x; mem_llbit_we = 1'bx; mem_llbit_value = 1'bx;
   endtask

   // Push the expected wb_* state for the coming edge, then let the edge happen.
   task automatic expect_wb(input logic [DW-1:0] wdata, input logic [AW-1:0] wd, input logic wreg,
                            input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                            input logic llwe, input logic llval, input logic [CW-1:0] cnt);
      exp_q.push_back({wdata, wd, wreg, whilo, hi, lo, llwe, llval, cnt});
      id_q.push_back(step);
      step++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int n;
      ctl(1'b1, '0, 1'b0, 1'b0);
      inp(32'hDEADBEEF, 5'd5, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);

      // Reset with a live GPR write on the inputs
      ctl(1'b1, '0, 1'b0, 1'b0);
      inp(32'hDEADBEEF, 5'd5, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      expect_wb('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0);

      // Pass-through with HI/LO
      ctl(1'b0, '0, 1'b0, 1'b0);
      inp(32'h12345678, 5'd3, 1'b1, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0);
      expect_wb(32'h12345678, 5'd3, 1'b1, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0, 4'd1);

      // Capture wd=7, then hold three cycles with X on the memory stage
      inp(32'h77, 5'd7, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      expect_wb(32'h77, 5'd7, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 4'd2);
      ctl(1'b0, 6'b110000, 1'b0, 1'b0);
      inp_x();
      for (int i = 0; i < 3; i++)
         expect_wb(32'h77, 5'd7, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 4'd2);

      // Memory stalled, write-back running: bubble
      ctl(1'b0, 6'b010000, 1'b0, 1'b0);
      expect_wb('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd2);

      // Capture wd=9 with LLbit, then flush under full stall
      ctl(1'b0, '0, 1'b0, 1'b0);
      inp(32'h99, 5'd9, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
      expect_wb(32'h99, 5'd9, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 4'd3);
      ctl(1'b0, 6'b111111, 1'b1, 1'b0);
      inp(32'hBB, 5'd11, 1'b1, 1'b1, 32'h1, 32'h2, 1'b1, 1'b1);
      expect_wb('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd3);

      // Unrelated stall bits ignored; capture with mem_wreg=0 does not count
      ctl(1'b0, 6'b001111, 1'b0, 1'b0);
      inp(32'hC, 5'd12, 1'b0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
      expect_wb(32'hC, 5'd12, 1'b0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0, 4'd3);

      // LLbit-only write
      ctl(1'b0, '0, 1'b0, 1'b0);
      inp('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      expect_wb('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd3);

      // Counter clear still works during a flush
      ctl(1'b0, '0, 1'b1, 1'b1);
      inp(32'h5, 5'd5, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      expect_wb('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0);

      // 17 qualifying captures: counter saturates at 15
      ctl(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) begin
         inp(32'(i) * 32'h101, AW'(i + 1), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
         expect_wb(32'(i) * 32'h101, AW'(i + 1), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0,
                   (i + 1 > 15) ? 4'd15 : CW'(i + 1));
      end

      // Clear beats a simultaneous qualifying capture
      ctl(1'b0, '0, 1'b0, 1'b1);
      inp(32'h44, 5'd4, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      expect_wb(32'h44, 5'd4, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0);
      ctl(1'b0, '0, 1'b0, 1'b0);
      inp(32'h66, 5'd6, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      expect_wb(32'h66, 5'd6, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 4'd1);

      // Reset during a hold discards the held entry
      ctl(1'b0, 6'b110000, 1'b0, 1'b0);
      inp_x();
      expect_wb(32'h66, 5'd6, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 4'd1);
      ctl(1'b1, 6'b110000, 1'b0, 1'b0);
      expect_wb('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0);
      ctl(1'b0, 6'b110000, 1'b0, 1'b0);
      expect_wb('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0);
      ctl(1'b0, '0, 1'b0, 1'b0);
      inp(32'hCAFEF00D, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
      expect_wb(32'hCAFEF00D, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 4'd1);

      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register, successor to the plain MEM/WB latch. Carries GPR write-back, HI/LO write-back and LLbit update from the memory stage to the write-back stage. Adds pipeline stall and flush control from the central control unit, bubble insertion, and a saturating retired-write counter for performance monitoring. Sits between the memory stage and the register file / HI-LO / LLbit write ports.

Parameters:
DATA_W, 32, width of GPR/HI/LO data
ADDR_W, 5, GPR address width
STALL_W, 6, width of control-unit stall vector
STAGE_IDX, 4, stall bit of the memory stage; STAGE_IDX+1 is the write-back stage bit; legal range 0..STALL_W-2
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  STALL_W  per-stage stall vector from control unit
flush  in  1  exception flush, squash this stage
cnt_clr  in  1  synchronous clear of retire counter
mem_wdata  in  DATA_W  GPR write data
mem_wd  in  ADDR_W  GPR destination address
mem_wreg  in  1  GPR write enable
mem_whilo  in  1  HI/LO write enable
mem_hi  in  DATA_W  HI write data
mem_lo  in  DATA_W  LO write data
mem_llbit_we  in  1  LLbit write enable
mem_llbit_value  in  1  LLbit value
wb_wdata  out  DATA_W  registered GPR write data
wb_wd  out  ADDR_W  registered GPR address
wb_wreg  out  1  registered GPR write enable
wb_whilo  out  1  registered HI/LO write enable
wb_hi  out  DATA_W  registered HI data
wb_lo  out  DATA_W  registered LO data
wb_llbit_we  out  1  registered LLbit write enable
wb_llbit_value  out  1  registered LLbit value
retire_cnt  out  CNT_W  count of GPR-writing instructions captured

Behaviour:
- All outputs registered; latency 1 cycle mem_* -> wb_*. No combinational path input->output.
- Let s_mem = stall[STAGE_IDX], s_wb = stall[STAGE_IDX+1].
- Pipeline register update, priority order, evaluated each rising edge:
  1. rst=1: all wb_* data/addr fields to 0, all enables to 0, retire_cnt to 0.
  2. flush=1: all wb_* to bubble (all fields 0, all enables 0). Overrides any stall.
  3. s_mem=1 and s_wb=0: insert bubble (same values as flush).
  4. s_mem=0: capture all mem_* into wb_*.
  5. otherwise (s_mem=1, s_wb=1): hold all wb_* unchanged.
- Bubble = NOP: wb_wd=0, wb_wreg=0, wb_whilo=0, wb_llbit_we=0, data fields 0.
- Enables are never asserted by a bubble or held register beyond what was captured; a held entry re-presents the same enables (write-back is idempotent).
- retire_cnt:
  - Increments by 1 on every edge where case 4 applies, rst=0, flush=0, and mem_wreg=1.
  - Does not increment on bubble, hold, flush, or captures with mem_wreg=0.
  - Saturates at 2^CNT_W-1; further qualifying captures leave it unchanged.
  - cnt_clr=1 sets it to 0 on the next edge; cnt_clr has priority over increment. Not affected by flush.
  - rst has priority over cnt_clr.
- Reset mid-operation: any held or in-flight entry discarded; first cycle after rst deassert resumes per priority list.
- stall bits other than STAGE_IDX and STAGE_IDX+1 are ignored.
- X on mem_* while s_mem=1 must not propagate to wb_*.

Test Plan:
- Reset: rst=1 one cycle with mem_wreg=1, mem_wd=5, mem_wdata=0xDEADBEEF -> next cycle all wb_*=0, retire_cnt=0.
- Pass-through: stall=0, mem_wd=3, mem_wdata=0x12345678, mem_wreg=1, mem_whilo=1, mem_hi=0xA, mem_lo=0xB -> one cycle later wb_wd=3, wb_wdata=0x12345678, wb_wreg=1, wb_whilo=1, wb_hi=0xA, wb_lo=0xB; retire_cnt=1.
- Hold vs bubble: capture wd=7 wreg=1; then stall=6'b110000 for 3 cycles -> wb_* hold wd=7 wreg=1, retire_cnt unchanged; then stall=6'b010000 -> wb_wreg=0, wb_wd=0 (bubble), retire_cnt unchanged.
- Flush priority: stall=6'b111111, flush=1 with wb holding wd=9 wreg=1 -> next cycle wb_wreg=0, wb_wd=0, wb_llbit_we=0; retire_cnt unchanged.
- Counter saturation/clear: CNT_W=4, 17 consecutive captures with mem_wreg=1 -> retire_cnt=15 and stays 15; cnt_clr=1 together with a qualifying capture -> retire_cnt=0.
- LLbit path: mem_llbit_we=1, mem_llbit_value=1, mem_wreg=0, stall=0 -> wb_llbit_we=1, wb_llbit_value=1, retire_cnt unchanged.
